// File: rtl/am_pwm_modulator.sv
// AM test-tone generator: a 16-entry sine LUT sets the duty cycle of a
// single-bit PWM output. Each sample is held for FOO PWM periods, so the
// low-pass filtered output carries an amplitude-modulated tone.
module am_pwm_modulator #(
  parameter int FOO                  = 10,
  parameter int AM_CLKS_IN_PWM_STEPS = 16,
  parameter int AM_PWM_STEPS         = 16
) (
  input  logic clk,
  input  logic rst,
  output logic pwm
);

  localparam int PRE_W  = (AM_CLKS_IN_PWM_STEPS > 1) ? $clog2(AM_CLKS_IN_PWM_STEPS) : 1;
  localparam int STEP_W = (AM_PWM_STEPS > 1) ? $clog2(AM_PWM_STEPS) : 1;
  localparam int PER_W  = (FOO > 1) ? $clog2(FOO) : 1;
  localparam int DUTY_W = $clog2(AM_PWM_STEPS) + 1;

  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(AM_CLKS_IN_PWM_STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(AM_PWM_STEPS - 1);
  localparam logic [PER_W-1:0]  PER_MAX  = PER_W'(FOO - 1);

  // 128 + round(127*sin(2*pi*k/16))
  function automatic logic [7:0] lut(input logic [3:0] k);
    logic [7:0] v;
    case (k)
      4'd0:  v = 8'd128;
      4'd1:  v = 8'd177;
      4'd2:  v = 8'd218;
      4'd3:  v = 8'd245;
      4'd4:  v = 8'd255;
      4'd5:  v = 8'd245;
      4'd6:  v = 8'd218;
      4'd7:  v = 8'd177;
      4'd8:  v = 8'd128;
      4'd9:  v = 8'd79;
      4'd10: v = 8'd38;
      4'd11: v = 8'd11;
      4'd12: v = 8'd1;
      4'd13: v = 8'd11;
      4'd14: v = 8'd38;
      default: v = 8'd79;
    endcase
    return v;
  endfunction

  // Map the 8-bit sample onto the step range; truncation keeps duty below
  // AM_PWM_STEPS so every period has at least one low step.
  function automatic logic [DUTY_W-1:0] scale(input logic [7:0] v);
    return DUTY_W'((32'(v) * 32'(AM_PWM_STEPS)) >> 8);
  endfunction

  logic [PRE_W-1:0]  pre;
  logic [STEP_W-1:0] step;
  logic [PER_W-1:0]  per;
  logic [3:0]        idx;
  logic [DUTY_W-1:0] duty;

  logic       step_tick, per_bound, samp_bound;
  logic [3:0] idx_nxt;

  // Tick/boundary decode and the index as it will be after this edge
  always_comb begin
    step_tick  = (pre == PRE_MAX);
    per_bound  = step_tick && (step == STEP_MAX);
    samp_bound = per_bound && (per == PER_MAX);
    idx_nxt    = samp_bound ? idx + 4'd1 : idx;
  end

  // Counter chain, period-aligned duty reload, registered PWM compare
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre  <= '0;
      step <= '0;
      per  <= '0;
      idx  <= '0;
      duty <= scale(lut(4'd0));
      pwm  <= 1'b0;
    end else begin
      pre <= step_tick ? '0 : pre + 1'b1;
      if (step_tick)
        step <= per_bound ? '0 : step + 1'b1;
      if (per_bound) begin
        per  <= samp_bound ? '0 : per + 1'b1;
        idx  <= idx_nxt;
        duty <= scale(lut(idx_nxt));
      end
      pwm <= ({1'b0, step} < duty);
    end
  end

endmodule

// File: tb/tb_am_pwm_modulator.sv
// Bench for am_pwm_modulator: every clock's pwm is compared against a model
// that derives the level from elapsed clocks since reset release.
module tb_am_pwm_modulator;
  localparam int FOO = 10;
  localparam int C   = 16;
  localparam int S   = 16;
  localparam int PERIOD = C * S;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm;

  int total = 0;
  int bad   = 0;
  int edges = 0;
  int lut [16] = '{128, 177, 218, 245, 255, 245, 218, 177,
                   128,  79,  38,  11,   1,  11,  38,  79};

  am_pwm_modulator #(.FOO(FOO), .AM_CLKS_IN_PWM_STEPS(C), .AM_PWM_STEPS(S)) dut (
    .clk(clk),
    .rst(rst),
    .pwm(pwm)
  );

  always #10 clk = ~clk;

  // Expected pwm after the t-th rising edge following release (t >= 1):
  // the output reflects the counter state of clock t-1.
  function automatic logic model(input int t);
    int c, pos, period, smp, duty;
    c      = t - 1;
    pos    = c % PERIOD;
    period = c / PERIOD;
    smp    = (period / FOO) % 16;
    duty   = (lut[smp] * S) >> 8;
    return ((pos / C) < duty);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0b want=%0b", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      chk($sformatf("pwm@%0d", edges), pwm, model(edges));
    end
  endtask

  // Assert reset between edges, verify the asynchronous clear and hold,
  // then release at a falling edge so the next rising edge is clock 1.
  task automatic async_reset(input string tag);
    #($urandom_range(1, 8));
    rst = 1'b0;
    #1;
    chk({tag, "_async"}, pwm, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_hold"}, pwm, 1'b0);
    end
    rst   = 1'b1;
    edges = 0;
  endtask

  initial begin
    int target;
    // Reset reached without any clock edge
    #2 rst = 1'b0;
    #1 chk("reset_noclk", pwm, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("reset_hold", pwm, 1'b0);
    end
    rst   = 1'b1;
    edges = 0;

    // Run into the high phase of a random period of sample 3, then reset
    target = 3 * FOO * PERIOD + PERIOD * $urandom_range(0, FOO - 1)
             + $urandom_range(2, 230);
    run(target);
    chk("pre_rst_high", pwm, 1'b1);
    async_reset("midper");

    // Full message cycle plus wrap into the next one
    run(16 * FOO * PERIOD + 600);

    // Random reset point, then a short run to confirm restart at sample 0
    run($urandom_range(1, 3000));
    async_reset("rand");
    run(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
